// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - three-row sliding window line buffer feeding the conv layer
// Define CONV_LB_STALL_CNT_EN to add the stall_cnt output.
module conv_line_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int W           = 64,
  parameter int H           = 64,
  parameter int HOLD_CYCLES = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [0:W*DATA_WIDTH-1] image0,
  output logic [0:W*DATA_WIDTH-1] image1,
  output logic [0:W*DATA_WIDTH-1] image2,
  output logic                    image_valid,
  output logic [$clog2(H)-1:0]    out_row,
  output logic                    frame_done
`ifdef CONV_LB_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);
  localparam int COL_W    = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W    = $clog2(H + 1);
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int ROW_BITS = W * DATA_WIDTH;

  typedef enum logic [1:0] {FILL, HOLD, GAP, IDLE} state_t;
  state_t state, state_n;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                pending;
  logic [0:ROW_BITS-1] asm_row;
  logic [0:ROW_BITS-1] row_next;
  logic [0:ROW_BITS-1] rot_row;
  logic                accept;
  logic                row_done;
  logic                busy;
  logic                rotate;
  logic                hold_last;

  assign in_ready  = !pending;
  assign accept    = in_valid && in_ready;
  assign row_done  = accept && (col == COL_W'(W - 1));
  assign busy      = (state == HOLD) || (state == GAP);
  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  // A row parked during HOLD/GAP lands in IDLE, or in FILL when the frame just ended
  assign rotate    = (row_done && !busy) || (pending && (state == IDLE || state == FILL));

  always_comb begin
    row_next = asm_row;
    row_next[(W-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    rot_row = pending ? asm_row : row_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    image_valid = 1'b0;
    frame_done  = 1'b0;
    case (state)
      FILL: if (rotate && row_cnt == ROW_W'(2)) state_n = HOLD;
      HOLD: begin
        image_valid = 1'b1;
        if (hold_last) state_n = GAP;
      end
      GAP: begin
        if (row_cnt == ROW_W'(H)) begin
          frame_done = 1'b1;
          state_n    = FILL;
        end else begin
          state_n = IDLE;
        end
      end
      IDLE: if (rotate) state_n = HOLD;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row_cnt  <= '0;
      hold_cnt <= '0;
      pending  <= 1'b0;
      out_row  <= '0;
      asm_row  <= '0;
      image0   <= '0;
      image1   <= '0;
      image2   <= '0;
    end else begin
      if (accept) begin
        asm_row[int'(col)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        col <= (col == COL_W'(W - 1)) ? '0 : col + 1'b1;
      end

      if (rotate) begin
        image0 <= image1;
        image1 <= image2;
        image2 <= rot_row;
      end

      if (rotate)                pending <= 1'b0;
      else if (row_done && busy) pending <= 1'b1;

      if (frame_done)  row_cnt <= '0;
      else if (rotate) row_cnt <= row_cnt + 1'b1;

      if (frame_done || state == FILL)  out_row <= '0;
      else if (state == IDLE && rotate) out_row <= out_row + 1'b1;

      if (state == HOLD && !hold_last) hold_cnt <= hold_cnt + 1'b1;
      else                             hold_cnt <= '0;
    end
  end

`ifdef CONV_LB_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (frame_done) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_line_buffer.sv
// tb/tb_conv_line_buffer.sv - scoreboard bench for conv_line_buffer at W=4, H=4, HOLD_CYCLES=12
// Define CONV_LB_STALL_CNT_EN to also exercise stall_cnt.
module tb_conv_line_buffer;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int HC = 12;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DW-1:0]        in_data = '0;
  logic [0:W*DW-1]      image0, image1, image2;
  logic                 image_valid;
  logic [$clog2(H)-1:0] out_row;
  logic                 frame_done;
`ifdef CONV_LB_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  typedef struct {
    logic [0:W*DW-1]      r0, r1, r2;
    logic [$clog2(H)-1:0] row;
  } win_t;

  win_t exp_q[$];
  win_t cur;
  int   total = 0;
  int   bad = 0;
  int   hold_len = 0;
  bit   iv_d = 1'b0;
  bit   frozen = 1'b1;

  conv_line_buffer #(.DATA_WIDTH(DW), .W(W), .H(H), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .image0(image0), .image1(image1), .image2(image2), .image_valid(image_valid),
    .out_row(out_row), .frame_done(frame_done)
`ifdef CONV_LB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [0:W*DW-1] make_row(input int base);
    logic [0:W*DW-1] r;
    for (int c = 0; c < W; c++) r[c*DW +: DW] = DW'(base + c);
    return r;
  endfunction

  function automatic win_t make_win(input int base, input int row);
    win_t w;
    w.r0  = make_row(base);
    w.r1  = make_row(base + W);
    w.r2  = make_row(base + 2*W);
    w.row = 2'(row);
    return w;
  endfunction

  // Window scoreboard: pop on every image_valid rise, then watch length and stability
  always @(negedge clk) begin
    if (!reset) begin
      iv_d = 1'b0;
      hold_len = 0;
    end else begin
      if (image_valid && !iv_d) begin
        hold_len = 1;
        frozen = 1'b1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL window_unexpected out_row=%0d required=no window", out_row);
        end else begin
          cur = exp_q.pop_front();
          if (image0 !== cur.r0 || image1 !== cur.r1 || image2 !== cur.r2 || out_row !== cur.row) begin
            bad++;
            $display("FAIL window_contents got=%h/%h/%h row=%0d want=%h/%h/%h row=%0d",
                     image0, image1, image2, out_row, cur.r0, cur.r1, cur.r2, cur.row);
          end
        end
      end else if (image_valid) begin
        hold_len++;
        if (image0 !== cur.r0 || image1 !== cur.r1 || image2 !== cur.r2 || out_row !== cur.row)
          frozen = 1'b0;
      end else if (iv_d) begin
        total++;
        if (hold_len !== HC || !frozen) begin
          bad++;
          $display("FAIL window_hold len=%0d stable=%0d want len=%0d stable=1", hold_len, frozen, HC);
        end
      end
      iv_d = image_valid;
    end
  end

  task automatic drive_pixel(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL beat_timeout pixel=%0d in_ready=%b want=1", v, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input int first, input int count, input bit bubble);
    for (int i = 0; i < count; i++) begin
      drive_pixel(first + i);
      if (bubble) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_window_end();
    int n = 0;
    while (image_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (image_valid !== 1'b0) begin
      bad++;
      $display("FAIL window_end_timeout image_valid=%b want=0", image_valid);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", tag, in_ready); end
    total++;
    if (image_valid !== 1'b0) begin bad++; $display("FAIL %s_image_valid got=%b want=0", tag, image_valid); end
    total++;
    if (out_row !== '0) begin bad++; $display("FAIL %s_out_row got=%0d want=0", tag, out_row); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL %s_frame_done got=%b want=0", tag, frame_done); end
    total++;
    if ({image0, image1, image2} !== '0) begin
      bad++;
      $display("FAIL %s_images got=%h/%h/%h want=0", tag, image0, image1, image2);
    end
`ifdef CONV_LB_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL %s_stall_cnt got=%0d want=0", tag, stall_cnt); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_init");
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(make_win(1, 0));
    stream(1, 12, 1'b0);
    drive_pixel(13);
    drive_pixel(14);
    in_data = DW'(15);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (image_valid !== 1'b1) begin bad++; $display("FAIL reset_pre_valid got=%b want=1", image_valid); end
    reset = 1'b0;
    #2;
    check_reset_state("reset_mid");
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    exp_q.push_back(make_win(1, 0));
    stream(1, 11, 1'b0);
    total++;
    if (image_valid !== 1'b0) begin bad++; $display("FAIL fill_early_valid got=%b want=0", image_valid); end
    drive_pixel(12);
    total++;
    if (image_valid !== 1'b1 || out_row !== '0) begin
      bad++;
      $display("FAIL fill_valid_rise got=%b row=%0d want=1 row=0", image_valid, out_row);
    end
  endtask

  task automatic test_overlap();
    int stall_n = 0;
    int low_n = 0;
    int n = 0;
    exp_q.push_back(make_win(5, 1));
    for (int i = 13; i <= 16; i++) drive_pixel(i);
    in_data = 32'hDEAD_BEEF;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL overlap_ready_drop got=%b want=0", in_ready); end
    while (!in_ready && n < 100) begin
      stall_n++;
      if (!image_valid) low_n++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL overlap_ready_timeout got=%b want=1", in_ready); end
    total++;
    if (stall_n !== 10) begin bad++; $display("FAIL overlap_stall_len got=%0d want=10", stall_n); end
    total++;
    if (low_n !== 2) begin bad++; $display("FAIL overlap_gap_len got=%0d want=2", low_n); end
    total++;
    if (image_valid !== 1'b1 || out_row !== 2'd1) begin
      bad++;
      $display("FAIL overlap_next_window got=%b row=%0d want=1 row=1", image_valid, out_row);
    end
`ifdef CONV_LB_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'(stall_n)) begin bad++; $display("FAIL overlap_stall_cnt got=%0d want=%0d", stall_cnt, stall_n); end
`endif
  endtask

  task automatic test_frame_end();
    int pulses = 0;
    int highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (frame_done) pulses++;
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL frame_done_pulses got=%0d want=1", pulses); end
    total++;
    if (out_row !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_end_state row=%0d ready=%b want row=0 ready=1", out_row, in_ready);
    end
`ifdef CONV_LB_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL frame_end_stall_cnt got=%0d want=0", stall_cnt); end
`endif
    stream(17, 8, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (image_valid) highs++;
      @(posedge clk); #1;
    end
    total++;
    if (highs !== 0) begin bad++; $display("FAIL refill_early_window got=%0d cycles want=0", highs); end
    exp_q.push_back(make_win(17, 0));
    stream(25, 4, 1'b0);
    total++;
    if (image_valid !== 1'b1) begin bad++; $display("FAIL refill_valid_rise got=%b want=1", image_valid); end
    wait_window_end();
  endtask

  task automatic test_bubbles();
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(make_win(1, 0));
    stream(1, 12, 1'b1);
    total++;
    if (image_valid !== 1'b1) begin bad++; $display("FAIL bubbles_valid got=%b want=1", image_valid); end
    wait_window_end();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overlap();
    test_frame_end();
    test_bubbles();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL windows_missing got=%0d pending want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want=finish earlier", $time);
    $fatal(1);
  end
endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Upstream feeder of the single-channel convolution layer.
- Accepts a raster-order pixel stream (one pixel per beat, valid/ready handshake) and assembles full image rows.
- Keeps the three most recent rows and presents them as image0/image1/image2 (oldest to newest), each W pixels wide.
- Raises image_valid for exactly HOLD_CYCLES cycles per window, with a mandatory low gap between windows, so the conv units run one complete accumulate cycle per output row.

Parameters:
- DATA_WIDTH, 32, bits per pixel.
- W, 64, image width in pixels.
- H, 64, image height in rows; must be >= 3.
- HOLD_CYCLES, 12, cycles image_valid stays high per window (F*F+3 for F=3, D=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  pixel beat valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DATA_WIDTH  pixel value.
- image0  output  [0:W*DATA_WIDTH-1]  oldest row of window (row r).
- image1  output  [0:W*DATA_WIDTH-1]  middle row (r+1).
- image2  output  [0:W*DATA_WIDTH-1]  newest row (r+2).
- image_valid  output  1  window stable and valid.
- out_row  output  $clog2(H)  index r of the top row of the current window.
- frame_done  output  1  one-cycle pulse after the last window of a frame.

Behaviour:
- Reset (reset=0, async): all rows, assembly register, counters = 0; state FILL; in_ready=1; image_valid=0; out_row=0; frame_done=0.
- Pixel c of a row (c=0 first received) occupies bits [c*DATA_WIDTH +: DATA_WIDTH] of every row bus.
- Handshake: a beat transfers when in_valid && in_ready. in_data is written to assembly register slot col; col increments and wraps to 0 after W-1.
- Row complete (beat with col==W-1):
  - If state is not HOLD/GAP, rotate on the same edge: image0<=image1, image1<=image2, image2<=assembled row; row_cnt++.
  - Otherwise set pending=1. in_ready=0 while pending. Rotation occurs in the first IDLE cycle; pending clears that cycle.
- States:
  - FILL: row_cnt<3. Rotate on each completed row. When the third row rotates in -> HOLD, out_row=0.
  - HOLD: image_valid=1. Hold counter runs 0..HOLD_CYCLES-1; at HOLD_CYCLES-1 -> GAP. image0..2 and out_row are frozen throughout.
  - GAP: image_valid=0 for exactly 1 cycle.
    - If row_cnt==H: pulse frame_done, clear row_cnt and out_row, -> FILL.
    - Else -> IDLE.
  - IDLE: image_valid=0. On a rotation (new or pending row): out_row++, -> HOLD in the next cycle.
- Windows per frame = H-2. Rows beyond H are never accepted within a frame; the next frame starts in FILL. Stale rows are not cleared, but image_valid stays low until three new rows are loaded.
- in_ready is asserted whenever pending=0, including during HOLD/GAP, so the next row assembles in parallel with the conv run.
- Counters are wide enough for W, H and HOLD_CYCLES; no arithmetic on pixel data.
- Reset mid-frame discards all state immediately; image_valid drops asynchronously.

Optional Feature:
- Macro: CONV_LB_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0]. It counts cycles with in_valid && !in_ready, saturates at 16'hFFFF, clears on reset and on frame_done.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: W=4, H=4, HOLD_CYCLES=12; hold reset low mid-stream -> image_valid=0, in_ready=1, out_row=0, all image buses 0 immediately.
- Fill: stream pixels 1..12 continuously -> image_valid rises the cycle after pixel 12 is accepted; image0={1,2,3,4}, image1={5,6,7,8}, image2={9,10,11,12}; out_row=0; high for exactly 12 cycles, then low for >=1 cycle.
- Overlap and stall: stream 13..16 during HOLD -> in_ready drops after 16 is accepted, until the GAP->IDLE transition. Then image0={5..8}, image1={9..12}, image2={13..16}, out_row=1.
- Frame end: after the out_row=1 window ends -> frame_done pulses once; pixel 17 starts a new FILL; no window is produced until 12 new pixels arrive.
- Bubbles: in_valid toggling 1/0 each cycle over 12 pixels -> same window contents as the fill test; image_valid held 12 cycles.
- With CONV_LB_STALL_CNT_EN: hold in_valid=1 through the stall in the overlap test -> stall_cnt equals the observed in_ready-low cycles with in_valid=1; it reads 0 after frame_done.
